// File: rtl/arb_rsp_demux.sv
// Response demultiplexer for the round-robin arbitration tree: an index FIFO remembers
// which upstream port issued each forwarded request and steers in-order responses back.
module arb_rsp_demux #(
    parameter int unsigned NumOut    = 4,
    parameter int unsigned DataWidth = 32,
    parameter type         DataType  = logic [DataWidth-1:0],
    parameter int unsigned MaxTrans  = 8,
    parameter int unsigned IdxWidth  = $clog2(NumOut),
    parameter int unsigned CntWidth  = $clog2(MaxTrans + 1)
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       flush_i,
    input  logic                       req_valid_i,
    input  logic [IdxWidth-1:0]        req_idx_i,
    output logic                       req_ready_o,
    input  logic                       rsp_valid_i,
    output logic                       rsp_ready_o,
    input  DataType                    rsp_data_i,
    output logic [NumOut-1:0]          rsp_valid_o,
    input  logic [NumOut-1:0]          rsp_ready_i,
    output DataType [NumOut-1:0]       rsp_data_o,
    output logic [CntWidth-1:0]        outstanding_o,
    output logic                       err_o
);

    localparam int unsigned PtrWidth = (MaxTrans > 1) ? $clog2(MaxTrans) : 1;

    logic [IdxWidth-1:0] idx_mem_r [MaxTrans];
    logic [PtrWidth-1:0] wr_ptr_r;
    logic [PtrWidth-1:0] rd_ptr_r;
    logic [CntWidth-1:0] count_r;
    logic                err_r;
    logic [IdxWidth-1:0] head_s;
    logic                nonempty_s;
    logic                full_s;
    logic                push_s;
    logic                pop_s;

    // Pointers wrap explicitly so MaxTrans need not be a power of two.
    function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] ptr);
        if (ptr == PtrWidth'(MaxTrans - 1)) begin
            return {PtrWidth{1'b0}};
        end else begin
            return ptr + PtrWidth'(1);
        end
    endfunction

    assign nonempty_s    = (count_r != CntWidth'(0));
    assign full_s        = (count_r == CntWidth'(MaxTrans));
    assign head_s        = idx_mem_r[rd_ptr_r];
    assign req_ready_o   = ~full_s & ~flush_i;
    assign rsp_ready_o   = nonempty_s & rsp_ready_i[head_s] & ~flush_i;
    assign push_s        = req_valid_i & req_ready_o;
    assign pop_s         = rsp_valid_i & rsp_ready_o;
    assign outstanding_o = count_r;
    assign err_o         = err_r;

    // Steer the response valid to the head port only; payload is broadcast.
    always_comb begin
        rsp_valid_o = {NumOut{1'b0}};
        for (int p = 0; p < NumOut; p++) begin
            rsp_data_o[p] = rsp_data_i;
        end
        if (rsp_valid_i && nonempty_s && !flush_i) begin
            rsp_valid_o[head_s] = 1'b1;
        end else begin
            rsp_valid_o = {NumOut{1'b0}};
        end
    end

    // Index storage; contents beyond the live window are don't-care, so no reset.
    always_ff @(posedge clk_i) begin
        if (push_s) begin
            idx_mem_r[wr_ptr_r] <= req_idx_i;
        end
    end

    // Pointer, occupancy and sticky-error state; flush clears like reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni || flush_i) begin
            wr_ptr_r <= {PtrWidth{1'b0}};
            rd_ptr_r <= {PtrWidth{1'b0}};
            count_r  <= {CntWidth{1'b0}};
            err_r    <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= ptr_inc(wr_ptr_r);
            end
            if (pop_s) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CntWidth'(1);
                2'b01:   count_r <= count_r - CntWidth'(1);
                default: count_r <= count_r;
            endcase
            if (rsp_valid_i && !nonempty_s) begin
                err_r <= 1'b1;
            end
        end
    end

    arb_rsp_demux_chk #(
        .NumOut   (NumOut),
        .DataType (DataType),
        .IdxWidth (IdxWidth),
        .CntWidth (CntWidth)
    ) u_chk (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .flush_i     (flush_i),
        .req_valid_i (req_valid_i),
        .req_idx_i   (req_idx_i),
        .rsp_valid_i (rsp_valid_i),
        .rsp_ready_o (rsp_ready_o),
        .rsp_data_i  (rsp_data_i),
        .outstanding (count_r)
    );

endmodule

// Interface protocol properties for arb_rsp_demux.
module arb_rsp_demux_chk #(
    parameter int unsigned NumOut   = 4,
    parameter type         DataType = logic [31:0],
    parameter int unsigned IdxWidth = 2,
    parameter int unsigned CntWidth = 4
) (
    input logic                clk_i,
    input logic                rst_ni,
    input logic                flush_i,
    input logic                req_valid_i,
    input logic [IdxWidth-1:0] req_idx_i,
    input logic                rsp_valid_i,
    input logic                rsp_ready_o,
    input DataType             rsp_data_i,
    input logic [CntWidth-1:0] outstanding
);

    localparam logic [IdxWidth:0] NumOutW = (IdxWidth + 1)'(NumOut);

    a_idx_legal: assert property (@(posedge clk_i) disable iff (!rst_ni)
        req_valid_i |-> ({1'b0, req_idx_i} < NumOutW));

    // A pending response must be held with stable payload until accepted.
    a_rsp_hold: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (rsp_valid_i && !rsp_ready_o && (outstanding != CntWidth'(0)) && !flush_i)
        |=> (rsp_valid_i && $stable(rsp_data_i)));

endmodule

// File: tb/tb_arb_rsp_demux.sv
// Randomized + directed bench for arb_rsp_demux with a queue-based reference model.
module tb_arb_rsp_demux;

    localparam int NumOut    = 4;
    localparam int DataWidth = 32;
    localparam int MaxTrans  = 8;
    localparam int IdxWidth  = 2;
    localparam int CntWidth  = 4;

    logic                                clk_i = 1'b0;
    logic                                rst_ni = 1'b0;
    logic                                flush_i = 1'b0;
    logic                                req_valid_i = 1'b0;
    logic [IdxWidth-1:0]                 req_idx_i = '0;
    logic                                req_ready_o;
    logic                                rsp_valid_i = 1'b0;
    logic                                rsp_ready_o;
    logic [DataWidth-1:0]                rsp_data_i = '0;
    logic [NumOut-1:0]                   rsp_valid_o;
    logic [NumOut-1:0]                   rsp_ready_i = '0;
    logic [NumOut-1:0][DataWidth-1:0]    rsp_data_o;
    logic [CntWidth-1:0]                 outstanding_o;
    logic                                err_o;

    int n_total = 0;
    int n_pass  = 0;

    // Reference model: queue of outstanding port indices plus sticky error.
    logic [IdxWidth-1:0] mq [$];
    logic                merr = 1'b0;
    logic                hold_rsp = 1'b0;

    logic                m_req_rdy, m_rsp_rdy, m_pop, m_push;
    logic [NumOut-1:0]   m_valid;
    int                  m_cnt;

    always #5 clk_i = ~clk_i;

    arb_rsp_demux #(
        .NumOut    (NumOut),
        .DataWidth (DataWidth),
        .MaxTrans  (MaxTrans)
    ) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .flush_i       (flush_i),
        .req_valid_i   (req_valid_i),
        .req_idx_i     (req_idx_i),
        .req_ready_o   (req_ready_o),
        .rsp_valid_i   (rsp_valid_i),
        .rsp_ready_o   (rsp_ready_o),
        .rsp_data_i    (rsp_data_i),
        .rsp_valid_o   (rsp_valid_o),
        .rsp_ready_i   (rsp_ready_i),
        .rsp_data_o    (rsp_data_o),
        .outstanding_o (outstanding_o),
        .err_o         (err_o)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: mid-cycle, compare DUT against the model, then advance the model.
    always @(negedge clk_i) begin
        if (!rst_ni) begin
            mq.delete();
            merr     = 1'b0;
            hold_rsp = 1'b0;
        end else begin
            m_cnt     = mq.size();
            m_req_rdy = (m_cnt != MaxTrans) && !flush_i;
            m_rsp_rdy = 1'b0;
            m_valid   = '0;
            if (m_cnt != 0 && !flush_i) begin
                m_rsp_rdy = rsp_ready_i[mq[0]];
                if (rsp_valid_i) m_valid[mq[0]] = 1'b1;
            end
            chk("req_ready", 64'(req_ready_o), 64'(m_req_rdy));
            chk("rsp_ready", 64'(rsp_ready_o), 64'(m_rsp_rdy));
            chk("outstanding", 64'(outstanding_o), 64'(m_cnt));
            chk("err", 64'(err_o), 64'(merr));
            if (rsp_valid_o != '0 || m_valid != '0) begin
                chk("route", 64'(rsp_valid_o), 64'(m_valid));
                for (int p = 0; p < NumOut; p++) begin
                    chk("data_bcast", 64'(rsp_data_o[p]), 64'(rsp_data_i));
                end
            end
            m_pop    = rsp_valid_i && m_rsp_rdy;
            m_push   = req_valid_i && m_req_rdy;
            hold_rsp = rsp_valid_i && !m_pop && (m_cnt != 0) && !flush_i;
            if (flush_i) begin
                mq.delete();
                merr = 1'b0;
            end else begin
                if (rsp_valid_i && m_cnt == 0) merr = 1'b1;
                if (m_pop) void'(mq.pop_front());
                if (m_push) mq.push_back(req_idx_i);
            end
        end
    end

    // Drive one cycle of inputs just after the edge, return mid-cycle.
    task automatic drive(input logic rv, input logic [IdxWidth-1:0] idx, input logic sv,
                         input logic [DataWidth-1:0] d, input logic [NumOut-1:0] rr,
                         input logic fl);
        @(posedge clk_i);
        #1;
        req_valid_i = rv;
        req_idx_i   = idx;
        rsp_valid_i = sv;
        rsp_data_i  = d;
        rsp_ready_i = rr;
        flush_i     = fl;
        @(negedge clk_i);
    endtask

    logic [NumOut-1:0]    ord_exp [4];
    logic [IdxWidth-1:0]  ord_idx [4];
    logic [DataWidth-1:0] dat;

    initial begin
        ord_idx[0] = 2'd3; ord_idx[1] = 2'd0; ord_idx[2] = 2'd3; ord_idx[3] = 2'd1;
        ord_exp[0] = 4'b1000; ord_exp[1] = 4'b0001; ord_exp[2] = 4'b1000; ord_exp[3] = 4'b0010;

        repeat (3) @(posedge clk_i);
        #1 rst_ni = 1'b1;
        @(negedge clk_i);
        chk("rst_req_ready", 64'(req_ready_o), 64'(1));
        chk("rst_rsp_ready", 64'(rsp_ready_o), 64'(0));
        chk("rst_rsp_valid", 64'(rsp_valid_o), 64'(0));
        chk("rst_outstanding", 64'(outstanding_o), 64'(0));
        chk("rst_err", 64'(err_o), 64'(0));

        // Single transaction
        drive(1'b1, 2'd2, 1'b0, 32'h0, 4'b0000, 1'b0);
        chk("single_cnt0", 64'(outstanding_o), 64'(0));
        dat = $urandom;
        drive(1'b0, 2'd0, 1'b1, dat, 4'b0100, 1'b0);
        chk("single_valid", 64'(rsp_valid_o), 64'(4'b0100));
        chk("single_ready", 64'(rsp_ready_o), 64'(1));
        chk("single_cnt1", 64'(outstanding_o), 64'(1));
        drive(1'b0, 2'd0, 1'b0, 32'h0, 4'b0000, 1'b0);
        chk("single_cnt_end", 64'(outstanding_o), 64'(0));

        // Ordering
        for (int i = 0; i < 4; i++) drive(1'b1, ord_idx[i], 1'b0, 32'h0, 4'b0000, 1'b0);
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 2'd0, 1'b1, $urandom, 4'b1111, 1'b0);
            chk("order_valid", 64'(rsp_valid_o), 64'(ord_exp[i]));
        end
        drive(1'b0, 2'd0, 1'b0, 32'h0, 4'b0000, 1'b0);

        // Full, and refused push alongside a pop
        for (int i = 0; i < MaxTrans; i++)
            drive(1'b1, 2'($urandom_range(NumOut - 1)), 1'b0, 32'h0, 4'b0000, 1'b0);
        drive(1'b0, 2'd0, 1'b0, 32'h0, 4'b0000, 1'b0);
        chk("full_req_ready", 64'(req_ready_o), 64'(0));
        chk("full_cnt", 64'(outstanding_o), 64'(MaxTrans));
        drive(1'b1, 2'd1, 1'b1, $urandom, 4'b1111, 1'b0);
        chk("full_push_refused", 64'(req_ready_o), 64'(0));
        chk("full_pop_ok", 64'(rsp_ready_o), 64'(1));
        drive(1'b0, 2'd0, 1'b0, 32'h0, 4'b0000, 1'b0);
        chk("full_cnt_after", 64'(outstanding_o), 64'(MaxTrans - 1));
        chk("full_ready_after", 64'(req_ready_o), 64'(1));
        for (int i = 0; i < MaxTrans - 1; i++) drive(1'b0, 2'd0, 1'b1, $urandom, 4'b1111, 1'b0);
        drive(1'b0, 2'd0, 1'b0, 32'h0, 4'b0000, 1'b0);
        chk("full_drained", 64'(outstanding_o), 64'(0));

        // Back-pressure from the head port only
        drive(1'b1, 2'd1, 1'b0, 32'h0, 4'b0000, 1'b0);
        dat = $urandom;
        drive(1'b0, 2'd0, 1'b1, dat, 4'b1101, 1'b0);
        chk("bp_held", 64'(rsp_ready_o), 64'(0));
        chk("bp_valid", 64'(rsp_valid_o), 64'(4'b0010));
        drive(1'b0, 2'd0, 1'b1, dat, 4'b1111, 1'b0);
        chk("bp_accept", 64'(rsp_ready_o), 64'(1));
        drive(1'b0, 2'd0, 1'b0, 32'h0, 4'b0000, 1'b0);
        chk("bp_cnt", 64'(outstanding_o), 64'(0));

        // Response with nothing outstanding
        drive(1'b0, 2'd0, 1'b1, $urandom, 4'b1111, 1'b0);
        chk("err_ready", 64'(rsp_ready_o), 64'(0));
        chk("err_not_yet", 64'(err_o), 64'(0));
        drive(1'b0, 2'd0, 1'b0, 32'h0, 4'b0000, 1'b0);
        chk("err_set", 64'(err_o), 64'(1));
        drive(1'b0, 2'd0, 1'b0, 32'h0, 4'b0000, 1'b0);
        chk("err_sticky", 64'(err_o), 64'(1));
        drive(1'b0, 2'd0, 1'b0, 32'h0, 4'b0000, 1'b1);
        drive(1'b0, 2'd0, 1'b0, 32'h0, 4'b0000, 1'b0);
        chk("err_flushed", 64'(err_o), 64'(0));

        // Flush with 5 outstanding plus a push and a response
        for (int i = 0; i < 5; i++)
            drive(1'b1, 2'($urandom_range(NumOut - 1)), 1'b0, 32'h0, 4'b0000, 1'b0);
        drive(1'b1, 2'd0, 1'b1, $urandom, 4'b1111, 1'b1);
        chk("flush_rsp_ready", 64'(rsp_ready_o), 64'(0));
        chk("flush_req_ready", 64'(req_ready_o), 64'(0));
        chk("flush_valid", 64'(rsp_valid_o), 64'(0));
        drive(1'b0, 2'd0, 1'b0, 32'h0, 4'b0000, 1'b0);
        chk("flush_cnt", 64'(outstanding_o), 64'(0));
        chk("flush_err", 64'(err_o), 64'(0));
        drive(1'b1, 2'd2, 1'b0, 32'h0, 4'b0000, 1'b0);
        drive(1'b0, 2'd0, 1'b1, $urandom, 4'b0100, 1'b0);
        chk("flush_restart", 64'(rsp_valid_o), 64'(4'b0100));
        drive(1'b0, 2'd0, 1'b0, 32'h0, 4'b0000, 1'b0);

        // Random traffic: fill-heavy phase then drain-heavy phase
        for (int i = 0; i < 2000; i++) begin
            @(posedge clk_i);
            #1;
            req_valid_i = ($urandom_range(99) < ((i < 1000) ? 50 : 20));
            req_idx_i   = 2'($urandom_range(NumOut - 1));
            rsp_ready_i = 4'($urandom);
            flush_i     = ($urandom_range(127) == 0);
            if (!hold_rsp) begin
                rsp_valid_i = (mq.size() != 0) && ($urandom_range(99) < 60);
                rsp_data_i  = $urandom;
            end
        end
        drive(1'b0, 2'd0, 1'b0, 32'h0, 4'b0000, 1'b0);
        drive(1'b0, 2'd0, 1'b0, 32'h0, 4'b0000, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
